// File: rtl/riscv_pc_pkg.sv
// Shared types and helpers for the fetch-stage program-counter generator.
//   - pc_state_e    : halt/resume FSM states
//   - redir_kind_e  : encoding of the redir_kind input
//   - align_mask()  : mask of target LSBs that must be zero for an aligned fetch
package riscv_pc_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HALT  = 2'd3
  } pc_state_e;

  typedef enum logic [1:0] {
    KIND_REL  = 2'd0,  // base + offset
    KIND_JALR = 2'd1,  // (base + offset) with bit 0 cleared
    KIND_ABS  = 2'd2,  // base
    KIND_RSVD = 2'd3   // ignored
  } redir_kind_e;

  // Widest address the mask helper supports.
  localparam int unsigned MAX_ADDR_W = 64;

  // Low 'lsb' bits set; callers truncate to their own address width.
  function automatic logic [MAX_ADDR_W-1:0] align_mask(input int unsigned lsb);
    return (MAX_ADDR_W'(1) << lsb) - MAX_ADDR_W'(1);
  endfunction

endpackage

// File: rtl/riscv_pc_target.sv
// Combinational redirect-target calculator.
// Ports:
//   kind_i        redirect kind (REL / JALR / ABS / RSVD)
//   base_i        base address
//   offset_i      sign-extended byte offset
//   target_o      computed target, modulo 2^ADDR_W
//   misaligned_o  target has a nonzero bit among its ALIGN_LSB low bits
//   kind_valid_o  kind is not the reserved code
module riscv_pc_target
  import riscv_pc_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned ALIGN_LSB = 2
) (
  input  logic [1:0]        kind_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [ADDR_W-1:0] offset_i,
  output logic [ADDR_W-1:0] target_o,
  output logic              misaligned_o,
  output logic              kind_valid_o
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(align_mask(ALIGN_LSB));

  logic [ADDR_W-1:0] sum;

  assign sum = base_i + offset_i;

  always_comb begin
    target_o     = base_i;
    kind_valid_o = 1'b1;
    case (kind_i)
      KIND_REL:  target_o = sum;
      KIND_JALR: target_o = sum & ~ADDR_W'(1);
      KIND_ABS:  target_o = base_i;
      default:   kind_valid_o = 1'b0;
    endcase
  end

  // A reserved kind never reports misalignment; it is simply ignored.
  assign misaligned_o = kind_valid_o && ((target_o & ALIGN_MASK) != '0);

endmodule

// File: rtl/riscv_pc_gen.sv
// Fetch-stage program-counter generator.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   pc_o             current byte fetch address
//   pc_valid_o       pc_o is presented to fetch
//   pc_ready_i       fetch accepts pc_o this cycle
//   redir_valid_i    redirect request pulse
//   redir_kind_i     0=REL, 1=JALR, 2=ABS, 3=reserved
//   redir_base_i     redirect base address
//   redir_offset_i   redirect byte offset (sign-extended)
//   halt_req_i       stop fetching
//   resume_req_i     restart fetching (only honoured while halted)
//   halted_o         FSM is in HALT
//   misalign_err_o   one-cycle pulse after a misaligned redirect
//   misalign_addr_o  last misaligned target, held until the next error
module riscv_pc_gen
  import riscv_pc_pkg::*;
#(
  parameter int unsigned       ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter int unsigned       INC          = 4,
  parameter int unsigned       ALIGN_LSB    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] pc_o,
  output logic              pc_valid_o,
  input  logic              pc_ready_i,
  input  logic              redir_valid_i,
  input  logic [1:0]        redir_kind_i,
  input  logic [ADDR_W-1:0] redir_base_i,
  input  logic [ADDR_W-1:0] redir_offset_i,
  input  logic              halt_req_i,
  input  logic              resume_req_i,
  output logic              halted_o,
  output logic              misalign_err_o,
  output logic [ADDR_W-1:0] misalign_addr_o
);

  pc_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              pend_valid_q, pend_valid_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;

  logic [ADDR_W-1:0] target;
  logic              misaligned;
  logic              kind_valid;
  logic              handshake;
  logic              redir_live;
  logic              redir_ok;
  logic              redir_bad;
  logic              resume_now;
  logic [ADDR_W-1:0] next_pc;

  riscv_pc_target #(
    .ADDR_W    (ADDR_W),
    .ALIGN_LSB (ALIGN_LSB)
  ) u_target (
    .kind_i       (redir_kind_i),
    .base_i       (redir_base_i),
    .offset_i     (redir_offset_i),
    .target_o     (target),
    .misaligned_o (misaligned),
    .kind_valid_o (kind_valid)
  );

  assign pc_valid_o = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign handshake  = pc_valid_o && pc_ready_i;

  // Redirects are only meaningful once out of BOOT.
  assign redir_live = redir_valid_i && kind_valid && (state_q != ST_BOOT);
  assign redir_ok   = redir_live && !misaligned;
  assign redir_bad  = redir_live && misaligned;
  assign resume_now = (state_q == ST_HALT) && resume_req_i;

  // Same-cycle redirect beats the buffered one, which beats sequential flow.
  assign next_pc = redir_ok     ? target      :
                   pend_valid_q ? pend_addr_q :
                                  pc_q + ADDR_W'(INC);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    err_d        = redir_bad;
    err_addr_d   = redir_bad ? target : err_addr_q;

    if (handshake) begin
      // Accepted pc advances; any redirect or buffered target is consumed.
      pc_d         = next_pc;
      pend_valid_d = 1'b0;
    end else if (resume_now && (redir_ok || pend_valid_q)) begin
      // The halted pc was never fetched, so it is only replaced when a
      // redirect is waiting; otherwise fetch restarts where it stopped.
      pc_d         = redir_ok ? target : pend_addr_q;
      pend_valid_d = 1'b0;
    end else if (redir_ok) begin
      // Presented pc must stay stable; remember the redirect for later.
      pend_valid_d = 1'b1;
      pend_addr_d  = target;
    end

    case (state_q)
      ST_BOOT:  state_d = ST_RUN;
      ST_RUN: begin
        if (halt_req_i) state_d = handshake ? ST_HALT : ST_DRAIN;
      end
      ST_DRAIN: begin
        if (handshake) state_d = ST_HALT;
      end
      ST_HALT: begin
        if (resume_req_i) state_d = ST_RUN;
      end
      default:  state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_BOOT;
      pc_q         <= RESET_VECTOR;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      err_q        <= 1'b0;
      err_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      err_q        <= err_d;
      err_addr_q   <= err_addr_d;
    end
  end

  assign pc_o            = pc_q;
  assign halted_o        = (state_q == ST_HALT);
  assign misalign_err_o  = err_q;
  assign misalign_addr_o = err_addr_q;

endmodule

// File: tb/tb_riscv_pc_gen.sv
module tb_riscv_pc_gen;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc;
  logic        pc_valid;
  logic        pc_ready;
  logic        redir_valid;
  logic [1:0]  redir_kind;
  logic [31:0] redir_base;
  logic [31:0] redir_offset;
  logic        halt_req;
  logic        resume_req;
  logic        halted;
  logic        misalign_err;
  logic [31:0] misalign_addr;

  int checks = 0;
  int errors = 0;

  riscv_pc_gen #(
    .ADDR_W       (32),
    .RESET_VECTOR (32'h100),
    .INC          (4),
    .ALIGN_LSB    (2)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pc_o            (pc),
    .pc_valid_o      (pc_valid),
    .pc_ready_i      (pc_ready),
    .redir_valid_i   (redir_valid),
    .redir_kind_i    (redir_kind),
    .redir_base_i    (redir_base),
    .redir_offset_i  (redir_offset),
    .halt_req_i      (halt_req),
    .resume_req_i    (resume_req),
    .halted_o        (halted),
    .misalign_err_o  (misalign_err),
    .misalign_addr_o (misalign_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One line per accepted fetch.
  always @(negedge clk) begin
    if (rst_n && pc_valid && pc_ready) $display("fetch pc=%08h", pc);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic redir(input logic [1:0] kind, input logic [31:0] base, input logic [31:0] off);
    redir_valid  = 1'b1;
    redir_kind   = kind;
    redir_base   = base;
    redir_offset = off;
  endtask

  task automatic no_redir();
    redir_valid  = 1'b0;
    redir_kind   = 2'd0;
    redir_base   = '0;
    redir_offset = '0;
  endtask

  initial begin
    rst_n      = 1'b0;
    pc_ready   = 1'b1;
    halt_req   = 1'b0;
    resume_req = 1'b0;
    no_redir();

    // 1. reset and boot
    tick();
    tick();
    chk("rst_pc", pc, 32'h100);
    chk("rst_valid", {31'd0, pc_valid}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_err", {31'd0, misalign_err}, 32'd0);
    chk("rst_eaddr", misalign_addr, 32'd0);
    rst_n = 1'b1;
    chk("boot_cycle1_valid", {31'd0, pc_valid}, 32'd0);
    tick();
    chk("boot_cycle2_valid", {31'd0, pc_valid}, 32'd1);
    chk("boot_pc0", pc, 32'h100);
    tick();
    chk("seq_pc1", pc, 32'h104);
    tick();
    chk("seq_pc2", pc, 32'h108);

    // 2. backpressure plus buffered redirect
    redir(2'd2, 32'h200, 32'h0);
    tick();
    chk("abs_to_200", pc, 32'h200);
    pc_ready = 1'b0;
    redir(2'd0, 32'h1F0, 32'h40);
    tick();
    chk("stall_pc_a", pc, 32'h200);
    chk("stall_valid", {31'd0, pc_valid}, 32'd1);
    no_redir();
    tick();
    chk("stall_pc_b", pc, 32'h200);
    pc_ready = 1'b1;
    tick();
    chk("pending_applied", pc, 32'h230);

    // 3. JALR, misaligned REL, reserved kind
    redir(2'd1, 32'h301, 32'h0);
    tick();
    chk("jalr_target", pc, 32'h300);
    redir(2'd0, 32'h300, 32'h2);
    tick();
    chk("misalign_seq_pc", pc, 32'h304);
    chk("misalign_err_hi", {31'd0, misalign_err}, 32'd1);
    chk("misalign_addr", misalign_addr, 32'h302);
    no_redir();
    tick();
    chk("misalign_err_lo", {31'd0, misalign_err}, 32'd0);
    chk("misalign_addr_held", misalign_addr, 32'h302);
    chk("post_err_pc", pc, 32'h308);
    redir(2'd3, 32'h40, 32'h0);
    tick();
    chk("rsvd_ignored_pc", pc, 32'h30C);
    chk("rsvd_no_err", {31'd0, misalign_err}, 32'd0);
    no_redir();

    // 4. halt via DRAIN, redirect while halted, resume
    pc_ready = 1'b0;
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    chk("drain_valid", {31'd0, pc_valid}, 32'd1);
    chk("drain_not_halted", {31'd0, halted}, 32'd0);
    tick();
    chk("drain_pc_held", pc, 32'h30C);
    pc_ready = 1'b1;
    tick();
    chk("halt_halted", {31'd0, halted}, 32'd1);
    chk("halt_valid", {31'd0, pc_valid}, 32'd0);
    chk("halt_pc", pc, 32'h310);
    redir(2'd2, 32'h800, 32'h0);
    tick();
    no_redir();
    chk("halt_pc_held", pc, 32'h310);
    resume_req = 1'b1;
    tick();
    resume_req = 1'b0;
    chk("resume_valid", {31'd0, pc_valid}, 32'd1);
    chk("resume_pc", pc, 32'h800);
    chk("resume_halted", {31'd0, halted}, 32'd0);
    tick();
    chk("resume_seq", pc, 32'h804);
    // halt with handshake in the same cycle goes straight to HALT
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    chk("direct_halt", {31'd0, halted}, 32'd1);
    chk("direct_halt_pc", pc, 32'h808);
    resume_req = 1'b1;
    tick();
    resume_req = 1'b0;
    chk("resume_nopend_pc", pc, 32'h808);

    // 5. wrap and overwrite
    redir(2'd2, 32'hFFFF_FFFC, 32'h0);
    tick();
    no_redir();
    chk("pc_top", pc, 32'hFFFF_FFFC);
    tick();
    chk("pc_wrap", pc, 32'h0);
    pc_ready = 1'b0;
    redir(2'd2, 32'h40, 32'h0);
    tick();
    redir(2'd2, 32'h80, 32'h0);
    tick();
    no_redir();
    chk("overwrite_stall_pc", pc, 32'h0);
    pc_ready = 1'b1;
    tick();
    chk("overwrite_pc", pc, 32'h80);

    // 6. async reset mid-DRAIN with a pending redirect
    pc_ready = 1'b0;
    halt_req = 1'b1;
    redir(2'd2, 32'h900, 32'h0);
    tick();
    halt_req = 1'b0;
    no_redir();
    chk("pre_rst_drain", {31'd0, pc_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_pc", pc, 32'h100);
    chk("async_rst_valid", {31'd0, pc_valid}, 32'd0);
    chk("async_rst_halted", {31'd0, halted}, 32'd0);
    pc_ready = 1'b1;
    #1;
    rst_n = 1'b1;
    tick();
    chk("reboot_pc", pc, 32'h100);
    chk("reboot_valid", {31'd0, pc_valid}, 32'd1);
    tick();
    chk("pending_discarded", pc, 32'h104);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_pc_gen.md
Name: riscv_pc_gen

Overview:
Parametrised program-counter generator for the fetch stage, successor to the fixed 8-bit word-indexed PC.
- Byte-addressed PC of configurable width with a programmable reset vector.
- Valid/ready handshake to instruction fetch.
- Three redirect kinds (relative, JALR, absolute) with a one-entry pending-redirect buffer.
- Halt/resume FSM, and misaligned-target detection that raises an error instead of branching.

Parameters:
ADDR_W, 32, PC and target width in bits.
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset; ADDR_W bits.
INC, 4, sequential increment in bytes; power of two ≥2.
ALIGN_LSB, 2, log2(INC); number of target LSBs that must be zero.

Ports:
clk  in  1  rising-edge clock.
rst_n  in  1  asynchronous active-low reset.
pc  out  ADDR_W  current fetch address.
pc_valid  out  1  pc is presented to fetch.
pc_ready  in  1  fetch accepts pc this cycle.
redir_valid  in  1  redirect request, single-cycle pulse.
redir_kind  in  2  0=REL (base+offset), 1=JALR ((base+offset)&~1), 2=ABS (base), 3=reserved (ignored).
redir_base  in  ADDR_W  base address (branch PC, rs1, or trap/mepc vector).
redir_offset  in  ADDR_W  sign-extended byte offset.
halt_req  in  1  request to stop fetching.
resume_req  in  1  request to restart fetching.
halted  out  1  FSM is in HALT.
misalign_err  out  1  one-cycle pulse: redirect target is misaligned.
misalign_addr  out  ADDR_W  offending target, held until the next error.

Behaviour:
- Reset (async, rst_n=0): pc=RESET_VECTOR, pc_valid=0, halted=0, misalign_err=0, misalign_addr=0, pending buffer empty, state=BOOT.
- FSM states: BOOT, RUN, DRAIN, HALT.
  - BOOT: pc_valid=0. Moves unconditionally to RUN on the first clock edge after reset release, so pc_valid=1 in the second cycle after release.
  - RUN: pc_valid=1. A handshake (pc_valid & pc_ready) updates pc on that edge to next_pc.
  - halt_req in RUN:
    - with a handshake the same cycle: go to HALT.
    - otherwise: go to DRAIN.
  - DRAIN: pc_valid=1 and pc held until the handshake, then HALT; pc takes next_pc on that edge.
  - HALT: pc_valid=0, halted=1, pc held. resume_req moves to RUN on the next edge.
    - If the pending buffer is valid, the pc presented after resume is the pending target and the buffer clears.
  - halt_req is ignored in HALT. resume_req is ignored outside HALT. Both asserted in RUN: halt wins.
- Stability rule: while pc_valid=1 and pc_ready=0, pc must not change. Redirects never alter a presented-but-unaccepted pc.
- Target compute (combinational, modulo 2^ADDR_W):
  - REL: sum = base+offset.
  - JALR: sum with bit0 cleared.
  - ABS: base.
- Misalignment: target[ALIGN_LSB-1:0]≠0 after the JALR masking.
  - Redirect is dropped.
  - misalign_err=1 in the following cycle; misalign_addr=target.
  - Pending buffer is unchanged.
- Reserved kind 3: ignored, no error.
- next_pc priority, highest first:
  1. Valid, aligned redirect in the same cycle.
  2. Pending buffer target.
  3. pc+INC, wrapping modulo 2^ADDR_W (e.g. ADDR_W=32: 32'hFFFF_FFFC → 32'h0).
  - Using the pending target clears the buffer.
- Pending buffer:
  - A valid, aligned redirect without a handshake the same cycle (any state except BOOT) is captured; a later redirect overwrites it.
  - Redirect plus handshake in the same cycle: the redirect is applied directly and the buffer clears.
  - Redirects in BOOT are ignored.
- Latency: handshake or redirect to new pc = 1 cycle. Redirect captured while pc_ready=0 takes effect at the next handshake.
- Reset mid-operation: everything returns to reset values immediately; the pending redirect is discarded.

Decomposition:
Package riscv_pc_pkg:
- State enum: BOOT, RUN, DRAIN, HALT.
- Redirect kind codes: REL, JALR, ABS, RSVD.
- Function computing the alignment mask from ALIGN_LSB.

Sub-module riscv_pc_target (combinational):
- Inputs: kind, base, offset.
- Outputs: target, misaligned, kind_valid.
- Parametrised by ADDR_W and ALIGN_LSB.

Top level holds the FSM, the pc register, the pending buffer and the error registers.

Test Plan:
1. Reset and boot: RESET_VECTOR=32'h100, pc_ready=1 → pc_valid rises in the 2nd cycle after release; pc sequence 0x100, 0x104, 0x108.
2. Backpressure plus redirect: pc=0x200, pc_ready=0; REL base=0x1F0 offset=0x40 pulsed → pc stays 0x200 while stalled. pc_ready=1 → 0x200 accepted, next pc=0x230.
3. JALR and misalign: JALR base=0x301 offset=0 → target 0x300 taken. REL base=0x300 offset=0x2 → no redirect; misalign_err pulses once; misalign_addr=0x302; pc continues sequentially.
4. Halt/resume: halt_req with pc_ready=0 → DRAIN holds pc_valid=1 until accepted, then halted=1 and pc_valid=0. ABS redirect to 0x800 while halted, then resume_req → pc_valid=1 with pc=0x800.
5. Wrap and overwrite: pc=32'hFFFF_FFFC accepted → next pc=0x0. Two redirects (0x40 then 0x80) while pc_ready=0 → next accepted pc after the stall is 0x80.
6. Async reset mid-DRAIN with a pending redirect: rst_n low → pc=RESET_VECTOR, pc_valid=0 and halted=0 immediately; the pending target is never issued.
